// File: rtl/pigment_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pigment_pkg
//  Purpose  : Shared types and constants for the pigment dispenser: sequencer
//             state encoding, recipe table, timing defaults, colour indices.
//  Revision : 1.0  initial release
// ============================================================================
package pigment_pkg;

    // Sequencer states, 3-bit encoding
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_R_DROP    = 3'd1,
        ST_R_TO_Y    = 3'd2,
        ST_Y_DROP    = 3'd3,
        ST_Y_TO_B    = 3'd4,
        ST_B_DROP    = 3'd5,
        ST_B_TO_HOME = 3'd6,
        ST_DONE      = 3'd7
    } state_t;

    // Timing and width defaults
    localparam int unsigned c_depth_default = 5;
    localparam int unsigned c_move_default  = 2;
    localparam int unsigned c_cnt_w_default = 10;

    // Colour index into a recipe row
    localparam int unsigned c_col_r = 0;
    localparam int unsigned c_col_y = 1;
    localparam int unsigned c_col_b = 2;

    // Drop rounds per colour for ids 0..7 (row = {r, y, b})
    localparam int unsigned c_recipe [0:7][0:2] = '{
        '{2, 4, 7},
        '{5, 0, 0},
        '{0, 5, 0},
        '{0, 0, 5},
        '{3, 3, 0},
        '{0, 3, 3},
        '{3, 0, 3},
        '{2, 2, 2}
    };

    // One bit per color_id value; ids 8..15 are unsupported
    localparam logic [15:0] c_valid_mask = 16'h00FF;

endpackage
`default_nettype wire

// File: rtl/pigment_recipe_rom.sv
`default_nettype none
// ============================================================================
//  Module   : pigment_recipe_rom
//  Purpose  : Combinational lookup from color_id to per-pigment drop rounds
//             plus a valid flag. Shared with the UI display block.
//  Revision : 1.0  initial release
// ============================================================================
module pigment_recipe_rom
    import pigment_pkg::*;
#(
    parameter int unsigned CNT_W = c_cnt_w_default
) (
    input  logic [3:0]       color_id,
    output logic [CNT_W-1:0] r_cnt,
    output logic [CNT_W-1:0] y_cnt,
    output logic [CNT_W-1:0] b_cnt,
    output logic             valid
);

    // Table lookup; invalid ids report zero counts
    always_comb begin
        valid = c_valid_mask[color_id];
        r_cnt = '0;
        y_cnt = '0;
        b_cnt = '0;
        if (valid) begin
            r_cnt = CNT_W'(c_recipe[color_id[2:0]][c_col_r]);
            y_cnt = CNT_W'(c_recipe[color_id[2:0]][c_col_y]);
            b_cnt = CNT_W'(c_recipe[color_id[2:0]][c_col_b]);
        end
    end

endmodule
`default_nettype wire

// File: rtl/pigment_dispense_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : pigment_dispense_sequencer
//  Purpose  : Runs the carriage red -> yellow -> blue -> home for a latched
//             recipe, driving one-hot motor enables and carriage direction.
//             Outputs are registered from the next state (Moore).
//  Revision : 1.0  initial release
// ============================================================================
module pigment_dispense_sequencer
    import pigment_pkg::*;
#(
    parameter int unsigned DEPTH = c_depth_default,
    parameter int unsigned MOVE  = c_move_default,
    parameter int unsigned CNT_W = c_cnt_w_default
) (
    input  logic       clk_cnt,
    input  logic       rst,
    input  logic       req,
    input  logic [3:0] color_id,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       en_r,
    output logic       en_y,
    output logic       en_b,
    output logic       dir
);

    // Tick counter must reach the longer of a drop round and the return trip
    localparam int unsigned c_sec_max = (DEPTH > 2 * MOVE) ? DEPTH : 2 * MOVE;
    localparam int unsigned c_sec_w   = (c_sec_max > 1) ? $clog2(c_sec_max) : 1;
    localparam logic [c_sec_w-1:0] c_sec_drop_last = c_sec_w'(DEPTH - 1);
    localparam logic [c_sec_w-1:0] c_sec_move_last = c_sec_w'(MOVE - 1);
    localparam logic [c_sec_w-1:0] c_sec_home_last = c_sec_w'(2 * MOVE - 1);
    localparam logic [c_sec_w-1:0] c_sec_one       = c_sec_w'(1);
    localparam logic [CNT_W-1:0]   c_cnt_one       = CNT_W'(1);

    logic [CNT_W-1:0]   w_rom_r;
    logic [CNT_W-1:0]   w_rom_y;
    logic [CNT_W-1:0]   w_rom_b;
    logic               w_rom_valid;
    logic [CNT_W-1:0]   w_cur_cnt;
    logic               w_drop_end;
    logic               w_accept;
    state_t             w_nxt;

    state_t             r_state;
    logic [c_sec_w-1:0] r_sec;
    logic [CNT_W-1:0]   r_rnd;
    logic [CNT_W-1:0]   r_cnt_r;
    logic [CNT_W-1:0]   r_cnt_y;
    logic [CNT_W-1:0]   r_cnt_b;

    pigment_recipe_rom #(
        .CNT_W (CNT_W)
    ) u_rom (
        .color_id (color_id),
        .r_cnt    (w_rom_r),
        .y_cnt    (w_rom_y),
        .b_cnt    (w_rom_b),
        .valid    (w_rom_valid)
    );

    assign w_accept = (r_state == ST_IDLE) && req && w_rom_valid;

    // Round target of the drop state in progress and its end condition
    always_comb begin
        w_cur_cnt = '0;
        case (r_state)
            ST_R_DROP: w_cur_cnt = r_cnt_r;
            ST_Y_DROP: w_cur_cnt = r_cnt_y;
            ST_B_DROP: w_cur_cnt = r_cnt_b;
            default:   w_cur_cnt = '0;
        endcase
        w_drop_end = (r_sec == c_sec_drop_last) && (r_rnd == w_cur_cnt - c_cnt_one);
    end

    // Next state; zero-round drops are skipped straight to the following move
    always_comb begin
        w_nxt = r_state;
        case (r_state)
            ST_IDLE:
                if (w_accept)
                    w_nxt = (w_rom_r != '0) ? ST_R_DROP : ST_R_TO_Y;
            ST_R_DROP:
                if (w_drop_end) w_nxt = ST_R_TO_Y;
            ST_R_TO_Y:
                if (r_sec == c_sec_move_last)
                    w_nxt = (r_cnt_y != '0) ? ST_Y_DROP : ST_Y_TO_B;
            ST_Y_DROP:
                if (w_drop_end) w_nxt = ST_Y_TO_B;
            ST_Y_TO_B:
                if (r_sec == c_sec_move_last)
                    w_nxt = (r_cnt_b != '0) ? ST_B_DROP : ST_B_TO_HOME;
            ST_B_DROP:
                if (w_drop_end) w_nxt = ST_B_TO_HOME;
            ST_B_TO_HOME:
                if (r_sec == c_sec_home_last) w_nxt = ST_DONE;
            ST_DONE:
                w_nxt = ST_IDLE;
            default:
                w_nxt = ST_IDLE;
        endcase
    end

    // State, counters, latched recipe and registered Moore outputs
    always_ff @(posedge clk_cnt or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_sec   <= '0;
            r_rnd   <= '0;
            r_cnt_r <= '0;
            r_cnt_y <= '0;
            r_cnt_b <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            en_r    <= 1'b0;
            en_y    <= 1'b0;
            en_b    <= 1'b0;
            dir     <= 1'b0;
        end else begin
            r_state <= w_nxt;

            if (w_accept) begin
                r_cnt_r <= w_rom_r;
                r_cnt_y <= w_rom_y;
                r_cnt_b <= w_rom_b;
            end

            if (w_nxt != r_state) begin
                r_sec <= '0;
                r_rnd <= '0;
            end else if (r_state == ST_R_DROP || r_state == ST_Y_DROP ||
                         r_state == ST_B_DROP) begin
                if (r_sec == c_sec_drop_last) begin
                    r_sec <= '0;
                    r_rnd <= r_rnd + c_cnt_one;
                end else begin
                    r_sec <= r_sec + c_sec_one;
                end
            end else if (r_state != ST_IDLE) begin
                r_sec <= r_sec + c_sec_one;
            end

            busy <= (w_nxt != ST_IDLE);
            done <= (w_nxt == ST_DONE);
            en_r <= (w_nxt == ST_R_DROP);
            en_y <= (w_nxt == ST_Y_DROP);
            en_b <= (w_nxt == ST_B_DROP);
            dir  <= (w_nxt == ST_B_TO_HOME);
            err  <= (r_state == ST_IDLE) && req && !w_rom_valid;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pigment_dispense_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pigment_dispense_sequencer
//  Purpose  : Self-checking bench; a per-tick expected output trace is built
//             from the recipe table and compared against the sequencer.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pigment_dispense_sequencer;

    localparam int c_depth = 5;
    localparam int c_move  = 2;

    // Expected vector layout: {err, busy, done, dir, en_r, en_y, en_b}
    localparam logic [6:0] c_v_idle = 7'b0000000;
    localparam logic [6:0] c_v_err  = 7'b1000000;
    localparam logic [6:0] c_v_move = 7'b0100000;
    localparam logic [6:0] c_v_home = 7'b0101000;
    localparam logic [6:0] c_v_done = 7'b0110000;
    localparam logic [6:0] c_v_r    = 7'b0100100;
    localparam logic [6:0] c_v_y    = 7'b0100010;
    localparam logic [6:0] c_v_b    = 7'b0100001;

    logic       clk_cnt;
    logic       rst;
    logic       req;
    logic [3:0] color_id;
    logic       busy, done, err, en_r, en_y, en_b, dir;

    int n_vec;
    int n_miss;
    logic [6:0] exp_q[$];

    int rcp_r [0:7] = '{2, 5, 0, 0, 3, 0, 3, 2};
    int rcp_y [0:7] = '{4, 0, 5, 0, 3, 3, 0, 2};
    int rcp_b [0:7] = '{7, 0, 0, 5, 0, 3, 3, 2};

    pigment_dispense_sequencer #(
        .DEPTH (c_depth),
        .MOVE  (c_move),
        .CNT_W (10)
    ) dut (
        .clk_cnt  (clk_cnt),
        .rst      (rst),
        .req      (req),
        .color_id (color_id),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .en_r     (en_r),
        .en_y     (en_y),
        .en_b     (en_b),
        .dir      (dir)
    );

    initial clk_cnt = 1'b0;
    always #5 clk_cnt = ~clk_cnt;

    task automatic chk(input string tag, input logic [6:0] got, input logic [6:0] want);
        n_vec++;
        if (got !== want) begin
            n_miss++;
            $display("FAIL %s at %0t: got %b expected %b", tag, $time, got, want);
        end
    endtask

    function automatic logic [6:0] outs();
        return {err, busy, done, dir, en_r, en_y, en_b};
    endfunction

    task automatic push_seg(input logic [6:0] v, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(v);
    endtask

    // Whole run as a tick-by-tick trace, including the forced idle tick after DONE
    task automatic launch(input int id);
        push_seg(c_v_r,    rcp_r[id] * c_depth);
        push_seg(c_v_move, c_move);
        push_seg(c_v_y,    rcp_y[id] * c_depth);
        push_seg(c_v_move, c_move);
        push_seg(c_v_b,    rcp_b[id] * c_depth);
        push_seg(c_v_home, 2 * c_move);
        push_seg(c_v_done, 1);
        push_seg(c_v_idle, 1);
    endtask

    // One tick: apply inputs, advance the model on the edge, compare after it
    task automatic step(input logic rq, input logic [3:0] cid);
        logic [6:0] e;
        logic [6:0] o;
        req      = rq;
        color_id = cid;
        @(posedge clk_cnt);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
        end else if (rq && cid < 4'd8) begin
            launch(int'(cid));
            e = exp_q.pop_front();
        end else if (rq) begin
            e = c_v_err;
        end else begin
            e = c_v_idle;
        end
        #1;
        o = outs();
        chk("outs", o, e);
        chk("onehot", {6'd0, ($countones({en_r, en_y, en_b}) > 1)}, 7'd0);
    endtask

    initial begin
        n_vec    = 0;
        n_miss   = 0;
        rst      = 1'b1;
        req      = 1'b0;
        color_id = 4'd0;

        // Reset state
        #1;
        chk("reset_async", outs(), c_v_idle);
        repeat (2) @(posedge clk_cnt);
        #1;
        chk("reset_held", outs(), c_v_idle);
        #2 rst = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b0, 4'd0);

        // color 0, single pulse; color_id wiggles while busy
        step(1'b1, 4'd0);
        for (int i = 0; i < 78; i++) step(1'b0, 4'($urandom_range(0, 15)));

        // color 2: red and blue skipped
        step(1'b1, 4'd2);
        for (int i = 0; i < 38; i++) step(1'b0, 4'd2);

        // invalid id 9, then a held invalid request
        step(1'b1, 4'd9);
        for (int i = 0; i < 3; i++) step(1'b0, 4'd9);
        for (int i = 0; i < 3; i++) step(1'b1, 4'd12);
        step(1'b0, 4'd0);

        // held req with color 7: two runs, glitching color_id during the first
        for (int i = 0; i < 80; i++)
            step(1'b1, (i >= 10 && i < 20) ? 4'd0 : 4'd7);
        for (int i = 0; i < 4; i++) step(1'b0, 4'd7);

        // Reset in the middle of B_DROP for color 0
        step(1'b1, 4'd0);
        for (int i = 0; i < 44; i++) step(1'b0, 4'd0);
        chk("in_b_drop", outs(), c_v_b);
        #3 rst = 1'b1;
        #1;
        chk("reset_mid_run", outs(), c_v_idle);
        @(posedge clk_cnt);
        #1;
        chk("reset_mid_held", outs(), c_v_idle);
        #2 rst = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 6; i++) step(1'b0, 4'd0);

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            logic       rq;
            logic [3:0] cid;
            rq  = ($urandom_range(0, 3) == 0);
            cid = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(8, 15))
                                              : 4'($urandom_range(0, 7));
            step(rq, cid);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
